vc_credit_counter: RTL and testbench

//   Per-virtual-channel credit tracker for one NoC router output port.

---
 rtl/vc_credit_counter.sv | 75 +++++++
 tb/tb_vc_credit_counter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vc_credit_counter.sv
// Per-virtual-channel credit tracker for one router output port.
// Each VC holds a saturating counter of downstream buffer slots, plus sticky protocol-error flags.
module vc_credit_counter #(
  parameter int NUM_VC     = 4,
  parameter int DEPTH      = 8,
  parameter int LOW_THRESH = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_VC-1:0]    incr_i,
  input  logic [NUM_VC-1:0]    decr_i,
  input  logic [NUM_VC-1:0]    flush_i,
  input  logic                 err_clr_i,
  output logic [NUM_VC-1:0]    credit_en_o,
  output logic [NUM_VC-1:0]    credit_low_o,
  output logic [NUM_VC*CW-1:0] credit_cnt_o,
  output logic [NUM_VC-1:0]    underflow_o,
  output logic [NUM_VC-1:0]    overflow_o
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] LOW_CNT  = CW'(LOW_THRESH);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      logic [CW-1:0] cnt_q, cnt_d;
      logic          uf_q, uf_d;
      logic          of_q, of_d;

      // Flags clear first so that a same-cycle error event below re-sets them.
      always_comb begin
        cnt_d = cnt_q;
        uf_d  = uf_q & ~err_clr_i;
        of_d  = of_q & ~err_clr_i;
        if (flush_i[gi]) begin
          cnt_d = FULL_CNT;
        end else if (decr_i[gi] && !incr_i[gi]) begin
          if (cnt_q == '0) begin
            uf_d = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE_CNT;
          end
        end else if (incr_i[gi] && !decr_i[gi]) begin
          if (cnt_q == FULL_CNT) begin
            of_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_CNT;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q <= FULL_CNT;
          uf_q  <= 1'b0;
          of_q  <= 1'b0;
        end else begin
          cnt_q <= cnt_d;
          uf_q  <= uf_d;
          of_q  <= of_d;
        end
      end

      assign credit_cnt_o[gi*CW +: CW] = cnt_q;
      assign credit_en_o[gi]           = (cnt_q != '0);
      assign credit_low_o[gi]          = (cnt_q <= LOW_CNT);
      assign underflow_o[gi]           = uf_q;
      assign overflow_o[gi]            = of_q;
    end
  endgenerate

endmodule

// File: tb/tb_vc_credit_counter.sv
// Directed bench for vc_credit_counter (NUM_VC=4, DEPTH=8, LOW_THRESH=1).
module tb_vc_credit_counter;
  localparam int NV = 4;
  localparam int CW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [NV-1:0]    incr_i, decr_i, flush_i;
  logic             err_clr_i;
  logic [NV-1:0]    credit_en_o, credit_low_o, underflow_o, overflow_o;
  logic [NV*CW-1:0] credit_cnt_o;

  int n_vec = 0;
  int n_bad = 0;

  vc_credit_counter #(.NUM_VC(4), .DEPTH(8), .LOW_THRESH(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .incr_i       (incr_i),
    .decr_i       (decr_i),
    .flush_i      (flush_i),
    .err_clr_i    (err_clr_i),
    .credit_en_o  (credit_en_o),
    .credit_low_o (credit_low_o),
    .credit_cnt_o (credit_cnt_o),
    .underflow_o  (underflow_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int cnt_of(input int v);
    return int'(credit_cnt_o[v*CW +: CW]);
  endfunction

  initial begin
    incr_i = '0; decr_i = '0; flush_i = '0; err_clr_i = 1'b0;
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    check("rst_cnt", int'(credit_cnt_o), 'h8888);
    check("rst_en",  int'(credit_en_o), 'hF);
    check("rst_low", int'(credit_low_o), 0);
    check("rst_uf",  int'(underflow_o), 0);
    check("rst_of",  int'(overflow_o), 0);
    #5 rst = 1'b1;
    step();
    check("idle_cnt", int'(credit_cnt_o), 'h8888);

    // Drain VC0 one credit per cycle
    decr_i = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("drain_cnt0_%0d", k), cnt_of(0), 8 - k);
      check($sformatf("drain_low0_%0d", k), int'(credit_low_o[0]), (8 - k <= 1) ? 1 : 0);
      check($sformatf("drain_en0_%0d", k), int'(credit_en_o[0]), (k == 8) ? 0 : 1);
    end
    decr_i = '0;
    check("drain_others", int'(credit_cnt_o[15:4]), 'h888);
    check("drain_en", int'(credit_en_o), 'hE);

    // Underflow on VC1, stickiness and clear
    decr_i = 4'b0010;
    repeat (8) step();
    check("uf_cnt1_zero", cnt_of(1), 0);
    check("uf_not_yet", int'(underflow_o), 0);
    step();
    check("uf_cnt1_hold", cnt_of(1), 0);
    check("uf_set", int'(underflow_o), 'h2);
    decr_i = '0;
    step();
    check("uf_sticky", int'(underflow_o), 'h2);
    decr_i = 4'b0010; err_clr_i = 1'b1;
    step();
    check("uf_set_wins", int'(underflow_o), 'h2);
    decr_i = '0;
    step();
    check("uf_cleared", int'(underflow_o), 0);
    err_clr_i = 1'b0;

    // Overflow on VC2; incr+decr at both bounds is a no-op
    incr_i = 4'b0100;
    step();
    check("of_cnt2", cnt_of(2), 8);
    check("of_set", int'(overflow_o), 'h4);
    incr_i = '0; err_clr_i = 1'b1;
    step();
    check("of_cleared", int'(overflow_o), 0);
    err_clr_i = 1'b0;
    incr_i = 4'b0101; decr_i = 4'b0101;
    step();
    check("net0_cnt0", cnt_of(0), 0);
    check("net0_cnt2", cnt_of(2), 8);
    check("net0_uf", int'(underflow_o), 0);
    check("net0_of", int'(overflow_o), 0);
    incr_i = 4'b0001; decr_i = '0;
    step();
    check("incr_cnt0", cnt_of(0), 1);
    check("incr_low", int'(credit_low_o), 'h3);
    check("incr_en", int'(credit_en_o), 'hD);
    incr_i = '0;

    // Flush on VC3 overrides a concurrent decr / incr
    decr_i = 4'b1000;
    repeat (6) step();
    check("fl_cnt3_pre", cnt_of(3), 2);
    flush_i = 4'b1000;
    step();
    check("fl_cnt3", cnt_of(3), 8);
    check("fl_uf", int'(underflow_o), 0);
    decr_i = '0; incr_i = 4'b1000;
    step();
    check("fl_full_cnt3", cnt_of(3), 8);
    check("fl_full_of", int'(overflow_o), 0);
    flush_i = '0; incr_i = '0;

    // Async reset mid-burst on VC0
    incr_i = 4'b0001;
    repeat (3) step();
    check("mid_cnt0_4", cnt_of(0), 4);
    incr_i = '0; decr_i = 4'b0001;
    step();
    check("mid_cnt0_3", cnt_of(0), 3);
    #3 rst = 1'b0;
    #1;
    check("async_cnt", int'(credit_cnt_o), 'h8888);
    check("async_en", int'(credit_en_o), 'hF);
    check("async_low", int'(credit_low_o), 0);
    decr_i = '0;
    #2 rst = 1'b1;
    step();
    check("post_rst_cnt", int'(credit_cnt_o), 'h8888);
    check("post_rst_err", int'(underflow_o | overflow_o), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
